// File: rtl/seq_det_pkg.sv
// Shared helpers for the serial sequence detector: prefix-function and
// next-state evaluation, used only as elaboration-time constants.
package seq_det_pkg;

  localparam int unsigned MAX_PAT_W = 16;

  // Width needed to encode states S0..S(pw), including the Moore full-match state.
  function automatic int unsigned state_width(input int unsigned pw);
    return $clog2(pw + 1);
  endfunction

  // Bit i of the pattern in arrival order (i=0 is the first bit received).
  function automatic logic pat_bit(input logic [MAX_PAT_W-1:0] pat, input int pw, input int i);
    return pat[pw-1-i];
  endfunction

  // Prefix function: longest proper prefix of the first m pattern bits that is also a suffix.
  function automatic int fail_tab(input logic [MAX_PAT_W-1:0] pat, input int pw, input int m);
    int  best;
    bit  ok;
    best = 0;
    for (int j = 1; j < m; j++) begin
      ok = 1'b1;
      for (int t = 0; t < j; t++) begin
        if (pat_bit(pat, pw, t) != pat_bit(pat, pw, m - j + t)) ok = 1'b0;
      end
      if (ok) best = j;
    end
    return best;
  endfunction

  // Plain KMP automaton step from prefix length k (k < pw) on bit x; may return pw.
  function automatic int delta(input logic [MAX_PAT_W-1:0] pat, input int pw, input int k,
                               input logic x);
    int  best;
    bit  ok;
    if (k < pw && pat_bit(pat, pw, k) == x) return k + 1;
    best = 0;
    for (int j = 1; j <= k; j++) begin
      ok = (pat_bit(pat, pw, j - 1) == x);
      for (int t = 0; t < j - 1; t++) begin
        if (pat_bit(pat, pw, t) != pat_bit(pat, pw, k - j + 1 + t)) ok = 1'b0;
      end
      if (ok) best = j;
    end
    return best;
  endfunction

  // Detector next state, folding in overlap policy and output timing mode.
  function automatic int next_state(input logic [MAX_PAT_W-1:0] pat, input int pw,
                                    input bit overlap, input bit mealy, input int k,
                                    input logic x);
    int base;
    int n;
    // The Moore full-match state continues from the restart point.
    base = k;
    if (k == pw) base = overlap ? fail_tab(pat, pw, pw) : 0;
    n = delta(pat, pw, base, x);
    // Mealy has no full-match state: completion jumps straight to the restart point.
    if (n == pw && mealy) n = overlap ? fail_tab(pat, pw, pw) : 0;
    return n;
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Control/status bundle between the serial input path and the detector.
interface seq_detector_param_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned ST_W  = 3
);
  logic             en;
  logic             x_in;
  logic             clr_cnt;
  logic             y_out;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;
  logic [ST_W-1:0]  state_o;

  modport master (
    output en, x_in, clr_cnt,
    input  y_out, match_cnt, cnt_sat, state_o
  );

  modport slave (
    input  en, x_in, clr_cnt,
    output y_out, match_cnt, cnt_sat, state_o
  );
endinterface

// File: rtl/seq_match_counter.sv
// Saturating event counter with sticky saturation flag and synchronous clear.
module seq_match_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  // Next count: clear wins over increment; hold once all-ones.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr_i) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == '1) sat_d = 1'b1;
    end
  end

  // Count and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with overlap and Mealy/Moore options.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter bit               MEALY   = 1'b1,
  parameter int unsigned      CNT_W   = 8
) (
  input logic                clk,
  input logic                reset,
  seq_detector_param_if.slave bus
);

  localparam int unsigned ST_W    = state_width(PAT_W);
  localparam int unsigned NUM_ST  = MEALY ? PAT_W : PAT_W + 1;
  localparam int unsigned TAB_N   = 2 ** ST_W;
  localparam logic [MAX_PAT_W-1:0] PAT16 = MAX_PAT_W'(PATTERN);
  localparam logic [ST_W-1:0] LAST_ST = ST_W'(PAT_W - 1);
  localparam logic [ST_W-1:0] FULL_ST = ST_W'(PAT_W);

  logic [ST_W-1:0] state_q, state_d;
  logic [ST_W-1:0] nxt0_tab [TAB_N];
  logic [ST_W-1:0] nxt1_tab [TAB_N];
  logic            match_mealy;
  logic            match_inc;
  logic [CNT_W-1:0] cnt;
  logic            sat;

  // Transition table is constant; unreachable encodings fall back to S0.
  for (genvar k = 0; k < TAB_N; k++) begin : g_tab
    if (k < NUM_ST) begin : g_live
      assign nxt0_tab[k] = ST_W'(next_state(PAT16, int'(PAT_W), OVERLAP, MEALY, k, 1'b0));
      assign nxt1_tab[k] = ST_W'(next_state(PAT16, int'(PAT_W), OVERLAP, MEALY, k, 1'b1));
    end else begin : g_dead
      assign nxt0_tab[k] = '0;
      assign nxt1_tab[k] = '0;
    end
  end

  // Next state and match-completion event.
  always_comb begin
    state_d = state_q;
    if (bus.en) state_d = bus.x_in ? nxt1_tab[state_q] : nxt0_tab[state_q];
    match_mealy = bus.en && (state_q == LAST_ST) && (bus.x_in == PATTERN[0]);
    if (MEALY) match_inc = match_mealy;
    else       match_inc = bus.en && (state_d == FULL_ST);
  end

  // State register; reset discards any partial match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= '0;
    else       state_q <= state_d;
  end

  seq_match_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (match_inc),
    .clr_i (bus.clr_cnt),
    .cnt_o (cnt),
    .sat_o (sat)
  );

  // Outputs; y_out is held low while reset is asserted in both modes.
  always_comb begin
    if (MEALY) bus.y_out = match_mealy && !reset;
    else       bus.y_out = (state_q == FULL_ST) && !reset;
    bus.match_cnt = cnt;
    bus.cnt_sat   = sat;
    bus.state_o   = state_q;
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param across several parameter sets.
module tb_seq_detector_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic x_in = 1'b0;
  logic clr_cnt = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  logic y_a, y_b, y_d, y_e, y_f;

  always #5 clk = ~clk;

  // a: 1011 ovl mealy; b: 1011 no-ovl mealy; c: 1011 ovl moore; d: 1011 CNT_W=2;
  // e: 1111 ovl; f: 1111 no-ovl
  seq_detector_param_if #(.CNT_W(8), .ST_W(3)) if_a ();
  seq_detector_param_if #(.CNT_W(8), .ST_W(3)) if_b ();
  seq_detector_param_if #(.CNT_W(8), .ST_W(3)) if_c ();
  seq_detector_param_if #(.CNT_W(2), .ST_W(3)) if_d ();
  seq_detector_param_if #(.CNT_W(8), .ST_W(3)) if_e ();
  seq_detector_param_if #(.CNT_W(8), .ST_W(3)) if_f ();

  assign if_a.en = en;  assign if_a.x_in = x_in;  assign if_a.clr_cnt = clr_cnt;
  assign if_b.en = en;  assign if_b.x_in = x_in;  assign if_b.clr_cnt = clr_cnt;
  assign if_c.en = en;  assign if_c.x_in = x_in;  assign if_c.clr_cnt = clr_cnt;
  assign if_d.en = en;  assign if_d.x_in = x_in;  assign if_d.clr_cnt = clr_cnt;
  assign if_e.en = en;  assign if_e.x_in = x_in;  assign if_e.clr_cnt = clr_cnt;
  assign if_f.en = en;  assign if_f.x_in = x_in;  assign if_f.clr_cnt = clr_cnt;

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MEALY(1'b1), .CNT_W(8))
    u_a (.clk(clk), .reset(reset), .bus(if_a));
  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .MEALY(1'b1), .CNT_W(8))
    u_b (.clk(clk), .reset(reset), .bus(if_b));
  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MEALY(1'b0), .CNT_W(8))
    u_c (.clk(clk), .reset(reset), .bus(if_c));
  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MEALY(1'b1), .CNT_W(2))
    u_d (.clk(clk), .reset(reset), .bus(if_d));
  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .MEALY(1'b1), .CNT_W(8))
    u_e (.clk(clk), .reset(reset), .bus(if_e));
  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1111), .OVERLAP(1'b0), .MEALY(1'b1), .CNT_W(8))
    u_f (.clk(clk), .reset(reset), .bus(if_f));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one bit at negedge, snapshot Mealy outputs before the edge, return #1 after it.
  task automatic send(input logic b, input logic e, input logic c);
    @(negedge clk);
    x_in = b;
    en = e;
    clr_cnt = c;
    #2;
    y_a = if_a.y_out;
    y_b = if_b.y_out;
    y_d = if_d.y_out;
    y_e = if_e.y_out;
    y_f = if_f.y_out;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    en = 1'b0;
    x_in = 1'b0;
    clr_cnt = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int strm   [7] = '{1, 0, 1, 1, 0, 1, 1};
  int ya_exp [7] = '{0, 0, 0, 1, 0, 0, 1};
  int sa_exp [7] = '{1, 2, 3, 1, 2, 3, 1};
  int yb_exp [7] = '{0, 0, 0, 1, 0, 0, 0};
  int sb_exp [7] = '{1, 2, 3, 0, 0, 1, 1};
  int sc_exp [7] = '{1, 2, 3, 4, 2, 3, 4};
  int ye_exp [6] = '{0, 0, 0, 1, 1, 1};
  int yf_exp [6] = '{0, 0, 0, 1, 0, 0};

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #1;
    check_eq("rst_state_a", 32'(if_a.state_o), 0);
    check_eq("rst_y_a", 32'(if_a.y_out), 0);
    check_eq("rst_y_c", 32'(if_c.y_out), 0);
    check_eq("rst_cnt_a", 32'(if_a.match_cnt), 0);
    check_eq("rst_sat_a", 32'(if_a.cnt_sat), 0);
    @(negedge clk);
    reset = 1'b0;

    // Stream 1011011 on overlap/non-overlap/Moore variants
    for (int i = 0; i < 7; i++) begin
      send(strm[i][0], 1'b1, 1'b0);
      check_eq($sformatf("p1_y_a[%0d]", i), 32'(y_a), 32'(ya_exp[i]));
      check_eq($sformatf("p1_st_a[%0d]", i), 32'(if_a.state_o), 32'(sa_exp[i]));
      check_eq($sformatf("p2_y_b[%0d]", i), 32'(y_b), 32'(yb_exp[i]));
      check_eq($sformatf("p2_st_b[%0d]", i), 32'(if_b.state_o), 32'(sb_exp[i]));
      check_eq($sformatf("p3_st_c[%0d]", i), 32'(if_c.state_o), 32'(sc_exp[i]));
      check_eq($sformatf("p3_y_c[%0d]", i), 32'(if_c.y_out), 32'(ya_exp[i]));
    end
    check_eq("p1_cnt_a", 32'(if_a.match_cnt), 2);
    check_eq("p2_cnt_b", 32'(if_b.match_cnt), 1);
    check_eq("p3_cnt_c", 32'(if_c.match_cnt), 2);

    // Asynchronous reset mid-pattern
    apply_reset();
    send(1'b1, 1'b1, 1'b0);
    send(1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    check_eq("p4_pre_st_a", 32'(if_a.state_o), 3);
    @(negedge clk);
    x_in = 1'b1;
    en = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    check_eq("p4_async_st_a", 32'(if_a.state_o), 0);
    check_eq("p4_async_y_a", 32'(if_a.y_out), 0);
    check_eq("p4_async_st_c", 32'(if_c.state_o), 0);
    @(negedge clk);
    reset = 1'b0;
    send(1'b1, 1'b1, 1'b0);
    check_eq("p4_after_y_a", 32'(y_a), 0);
    check_eq("p4_after_st_a", 32'(if_a.state_o), 1);
    check_eq("p4_after_cnt_a", 32'(if_a.match_cnt), 0);

    // en gaps between bits of 1011
    apply_reset();
    send(1'b1, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    check_eq("p4_hold1_st_a", 32'(if_a.state_o), 1);
    send(1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    check_eq("p4_hold2_st_a", 32'(if_a.state_o), 2);
    send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    check_eq("p4_hold3_y_a", 32'(y_a), 0);
    check_eq("p4_hold3_st_a", 32'(if_a.state_o), 3);
    check_eq("p4_hold3_cnt_a", 32'(if_a.match_cnt), 0);
    send(1'b1, 1'b1, 1'b0);
    check_eq("p4_match_y_a", 32'(y_a), 1);
    check_eq("p4_match_cnt_a", 32'(if_a.match_cnt), 1);
    check_eq("p4_match_st_c", 32'(if_c.state_o), 4);
    check_eq("p4_match_y_c", 32'(if_c.y_out), 1);
    send(1'b0, 1'b0, 1'b0);
    check_eq("p4_idle_y_a", 32'(y_a), 0);
    check_eq("p4_idle_st_c", 32'(if_c.state_o), 4);
    check_eq("p4_idle_y_c", 32'(if_c.y_out), 1);
    check_eq("p4_idle_cnt_c", 32'(if_c.match_cnt), 1);

    // Saturation with CNT_W=2, then clear coincident with a match
    apply_reset();
    send(1'b1, 1'b1, 1'b0);
    send(1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    check_eq("p5_y_d[1]", 32'(y_d), 1);
    check_eq("p5_cnt_d[1]", 32'(if_d.match_cnt), 1);
    check_eq("p5_sat_d[1]", 32'(if_d.cnt_sat), 0);
    for (int m = 2; m <= 5; m++) begin
      send(1'b0, 1'b1, 1'b0);
      send(1'b1, 1'b1, 1'b0);
      send(1'b1, 1'b1, 1'b0);
      check_eq($sformatf("p5_y_d[%0d]", m), 32'(y_d), 1);
      check_eq($sformatf("p5_cnt_d[%0d]", m), 32'(if_d.match_cnt), (m < 3) ? m : 3);
      check_eq($sformatf("p5_sat_d[%0d]", m), 32'(if_d.cnt_sat), (m >= 3) ? 1 : 0);
    end
    send(1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b1);
    check_eq("p5_clr_y_d", 32'(y_d), 1);
    check_eq("p5_clr_cnt_d", 32'(if_d.match_cnt), 0);
    check_eq("p5_clr_sat_d", 32'(if_d.cnt_sat), 0);
    check_eq("p5_clr_st_d", 32'(if_d.state_o), 1);
    send(1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    check_eq("p5_post_cnt_d", 32'(if_d.match_cnt), 1);
    check_eq("p5_post_sat_d", 32'(if_d.cnt_sat), 0);

    // All-ones pattern, six consecutive 1s
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 1'b1, 1'b0);
      check_eq($sformatf("p6_y_e[%0d]", i), 32'(y_e), 32'(ye_exp[i]));
      check_eq($sformatf("p6_y_f[%0d]", i), 32'(y_f), 32'(yf_exp[i]));
    end
    check_eq("p6_cnt_e", 32'(if_e.match_cnt), 3);
    check_eq("p6_cnt_f", 32'(if_f.match_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
